// File: rtl/regfile_port_arbiter.sv
// Purpose: round-robin share of the single RegFile access port between two requesters.
// Latency: grant registered one edge after REQ is sampled; read data returns two cycles after the grant.
// Backpressure: REQ is held until GNT; one access is in flight at a time, reads are bounded by RD_TIMEOUT.
module regfile_port_arbiter #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int RD_TIMEOUT = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  M0_REQ,
   input  logic                  M0_WR,
   input  logic [ADDR_WIDTH-1:0] M0_ADDR,
   input  logic [DATA_WIDTH-1:0] M0_WDATA,
   output logic                  M0_GNT,
   output logic [DATA_WIDTH-1:0] M0_RDATA,
   output logic                  M0_RVALID,
   output logic                  M0_RERR,
   input  logic                  M1_REQ,
   input  logic                  M1_WR,
   input  logic [ADDR_WIDTH-1:0] M1_ADDR,
   input  logic [DATA_WIDTH-1:0] M1_WDATA,
   output logic                  M1_GNT,
   output logic [DATA_WIDTH-1:0] M1_RDATA,
   output logic                  M1_RVALID,
   output logic                  M1_RERR,
   output logic [ADDR_WIDTH-1:0] RF_ADDR,
   output logic                  RF_WREN,
   output logic                  RF_RDEN,
   output logic [DATA_WIDTH-1:0] RF_WRDATA,
   input  logic [DATA_WIDTH-1:0] RF_RDDATA,
   input  logic                  RF_RDVALID,
   output logic                  BUSY
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_RD_WAIT = 2'd2
   } state_t;

   // Last count value of the read wait window; RD_TIMEOUT is limited to 1..15.
   localparam logic [3:0] CNT_LAST = 4'(RD_TIMEOUT - 1);

   state_t                state_q, state_d;
   logic                  last_q, last_d;       // requester granted most recently
   logic                  owner_q, owner_d;     // requester owning the access in flight
   logic                  rd_op_q, rd_op_d;     // access in flight is a read
   logic [3:0]            cnt_q, cnt_d;
   logic [1:0]            gnt_q, gnt_d;
   logic [1:0]            rvalid_q, rvalid_d;
   logic [1:0]            rerr_q, rerr_d;
   logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
   logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
   logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
   logic                  rf_wren_q, rf_wren_d;
   logic                  rf_rden_q, rf_rden_d;
   logic [DATA_WIDTH-1:0] rf_wrdata_q, rf_wrdata_d;
   logic                  busy_q, busy_d;

   logic                  sel;
   logic                  sel_wr;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   // Next-state and registered-output decode: arbitrate in IDLE, strobe for one cycle, then collect read data.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      owner_d     = owner_q;
      rd_op_d     = rd_op_q;
      cnt_d       = cnt_q;
      gnt_d       = '0;
      rvalid_d    = '0;
      rerr_d      = '0;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;
      rf_addr_d   = rf_addr_q;
      rf_wren_d   = 1'b0;
      rf_rden_d   = 1'b0;
      rf_wrdata_d = rf_wrdata_q;

      // On a tie the requester that did not win last time goes first.
      sel       = (M0_REQ && M1_REQ) ? ~last_q : M1_REQ;
      sel_wr    = sel ? M1_WR    : M0_WR;
      sel_addr  = sel ? M1_ADDR  : M0_ADDR;
      sel_wdata = sel ? M1_WDATA : M0_WDATA;

      case (state_q)
         S_IDLE: begin
            if (M0_REQ || M1_REQ) begin
               gnt_d[sel] = 1'b1;
               last_d     = sel;
               owner_d    = sel;
               rd_op_d    = ~sel_wr;
               rf_addr_d  = sel_addr;
               rf_wren_d  = sel_wr;
               rf_rden_d  = ~sel_wr;
               if (sel_wr) begin
                  rf_wrdata_d = sel_wdata;
               end
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = rd_op_q ? S_RD_WAIT : S_IDLE;
         end
         S_RD_WAIT: begin
            if (RF_RDVALID) begin
               rvalid_d[owner_q] = 1'b1;
               if (owner_q) begin
                  rdata1_d = RF_RDDATA;
               end else begin
                  rdata0_d = RF_RDDATA;
               end
               state_d = S_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               // Abort: report an error with zeroed data to the owner only.
               rvalid_d[owner_q] = 1'b1;
               rerr_d[owner_q]   = 1'b1;
               if (owner_q) begin
                  rdata1_d = '0;
               end else begin
                  rdata0_d = '0;
               end
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers; reset abandons any access in flight without a completion pulse.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= S_IDLE;
         last_q      <= 1'b1;
         owner_q     <= 1'b0;
         rd_op_q     <= 1'b0;
         cnt_q       <= '0;
         gnt_q       <= '0;
         rvalid_q    <= '0;
         rerr_q      <= '0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         rf_addr_q   <= '0;
         rf_wren_q   <= 1'b0;
         rf_rden_q   <= 1'b0;
         rf_wrdata_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         owner_q     <= owner_d;
         rd_op_q     <= rd_op_d;
         cnt_q       <= cnt_d;
         gnt_q       <= gnt_d;
         rvalid_q    <= rvalid_d;
         rerr_q      <= rerr_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
         rf_addr_q   <= rf_addr_d;
         rf_wren_q   <= rf_wren_d;
         rf_rden_q   <= rf_rden_d;
         rf_wrdata_q <= rf_wrdata_d;
         busy_q      <= busy_d;
      end
   end

   assign M0_GNT    = gnt_q[0];
   assign M0_RDATA  = rdata0_q;
   assign M0_RVALID = rvalid_q[0];
   assign M0_RERR   = rerr_q[0];
   assign M1_GNT    = gnt_q[1];
   assign M1_RDATA  = rdata1_q;
   assign M1_RVALID = rvalid_q[1];
   assign M1_RERR   = rerr_q[1];
   assign RF_ADDR   = rf_addr_q;
   assign RF_WREN   = rf_wren_q;
   assign RF_RDEN   = rf_rden_q;
   assign RF_WRDATA = rf_wrdata_q;
   assign BUSY      = busy_q;

endmodule

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
- Round-robin arbiter that shares the single RegFile access port (Address/WrEn/RdEn/WrData in, RdData/RdData_Valid out) between two requesters in the REF_CLK domain.
- Requester 0 is the system controller command path. Requester 1 is a secondary master, such as a config loader or debug port.
- Serialises accesses, routes read data back to the issuing requester, and bounds each read with a timeout.

Parameters:
ADDR_WIDTH, 4, RegFile address width
DATA_WIDTH, 8, RegFile data width
RD_TIMEOUT, 4, max cycles in RD_WAIT before a read is aborted with error (legal 1..15)

Ports:
CLK  in  1  REF_CLK domain clock
RST  in  1  asynchronous active-low reset
M0_REQ  in  1  requester 0 access request; held until M0_GNT seen
M0_WR  in  1  1 = write, 0 = read; stable while M0_REQ high
M0_ADDR  in  ADDR_WIDTH  requester 0 address
M0_WDATA  in  DATA_WIDTH  requester 0 write data
M0_GNT  out  1  one-cycle grant pulse
M0_RDATA  out  DATA_WIDTH  read return data
M0_RVALID  out  1  one-cycle read-complete pulse
M0_RERR  out  1  qualifies M0_RVALID; 1 = read timed out
M1_REQ, M1_WR, M1_ADDR, M1_WDATA, M1_GNT, M1_RDATA, M1_RVALID, M1_RERR  as above, for requester 1
RF_ADDR  out  ADDR_WIDTH  to RegFile Address
RF_WREN  out  1  to RegFile WrEn
RF_RDEN  out  1  to RegFile RdEn
RF_WRDATA  out  DATA_WIDTH  to RegFile WrData
RF_RDDATA  in  DATA_WIDTH  from RegFile RdData
RF_RDVALID  in  1  from RegFile RdData_Valid
BUSY  out  1  high in every state except IDLE

Behaviour:
- All outputs are registered.
- Reset, asynchronous: state=IDLE, all GNT/RVALID/RERR/RF_WREN/RF_RDEN = 0, RF_ADDR/RF_WRDATA/RDATA = 0, timeout counter = 0, last_grant = 1 (so M0 wins the first tie).
- Reset asserted mid-transaction aborts it silently. No RVALID is produced for the aborted access.
- States: IDLE, ISSUE, RD_WAIT.
- IDLE:
  - Sample requests at the clock edge.
  - Only one request high -> grant it.
  - Both high -> grant the requester that is not last_grant, then update last_grant.
  - On a grant: go to ISSUE. In the same edge, register Mx_GNT=1, RF_ADDR=Mx_ADDR, and RF_WREN=Mx_WR / RF_RDEN=~Mx_WR. RF_WRDATA=Mx_WDATA on writes.
  - Latch the owner ID and op type.
- ISSUE (exactly 1 cycle):
  - GNT and RF strobes are high for this cycle only and drop at the next edge.
  - Write -> IDLE. Read -> RD_WAIT, with counter cleared to 0.
- No grant is ever issued in the cycle immediately following ISSUE. The requester updates or drops REQ on the edge where it samples GNT=1.
- Throughput: at most 1 transaction per 2 cycles.
- RD_WAIT:
  - RF_RDVALID=1 -> Mx_RDATA<=RF_RDDATA, Mx_RVALID<=1 and RERR<=0 for the owner, then -> IDLE.
  - Otherwise counter++. Counter == RD_TIMEOUT-1 with no valid -> owner RVALID=1, RERR=1, RDATA=0, then -> IDLE.
  - RVALID/RERR are single-cycle pulses.
  - The non-owner's RDATA holds its last value.
- With the RegFile's 1-cycle read latency: GNT at cycle t, RF_RDVALID at t+1, Mx_RVALID at t+2.
- RF_RDVALID arriving in IDLE or ISSUE (stray or late after timeout) is ignored and produces no RVALID.
- A requester that drops REQ before GNT is not granted. A request is only latched at the granting edge.
- Starvation bound: with both requesters continuously requesting, they alternate strictly. Maximum wait = one full read of the other requester + 1 cycle.

Test Plan:
- Single write: M0_REQ=1, WR=1, ADDR=4'h2, WDATA=8'hA5 -> M0_GNT and RF_WREN high for 1 cycle with RF_ADDR=2, RF_WRDATA=A5. BUSY=1 for 1 cycle. No RVALID.
- Single read: M1 reads ADDR=4'h3 and the RegFile model returns 8'h3C one cycle later -> M1_RVALID=1, M1_RERR=0, M1_RDATA=3C, exactly 2 cycles after M1_GNT. M0 outputs stay idle.
- Contention: M0 and M1 both hold REQ for writes to addresses 0 and 1 -> grants in order M0, M1, M0, M1, with one idle cycle between each. Addresses alternate 0, 1, 0, 1.
- Timeout: M0 read with RF_RDVALID tied 0 and RD_TIMEOUT=4 -> M0_RVALID=1 and M0_RERR=1 with M0_RDATA=0, 4 cycles after entering RD_WAIT. A later stray RF_RDVALID produces no pulse.
- Reset mid-read: assert RST low during RD_WAIT -> all outputs 0 immediately (async). After release, the first tie grants M0.
- Ownership routing: M1 read pending while M0_REQ is asserted -> M0 is not granted until M1_RVALID completes. M0's RDATA is unchanged by M1's return.
